// File: rtl/io_seq_pkg.sv
// io_seq_pkg
// Shared types for the I/O sequencer: the control FSM state encoding and the
// width of the byte counter used for both receive assembly and transmit
// serialisation.
package io_seq_pkg;

  // Byte counter width; enough to index up to four bytes of a 32-bit word.
  localparam int COUNT_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    TX_SEND,
    TX_GUARD,
    DONE
  } state_t;

endpackage

// File: rtl/rx_byte_buffer.sv
// rx_byte_buffer
// One-byte holding register for received bytes that the sequencer cannot
// consume in the cycle they arrive. A push while the byte is still held and
// not being popped is dropped and raises a sticky overrun flag.
//
// Ports:
//   clk      clock
//   reset    synchronous active-high reset (empties buffer, clears overrun)
//   wr       a byte arrives that must be stored
//   rd       the held byte is consumed this cycle
//   wr_data  byte to store
//   full     a byte is held
//   data     the held byte
//   overrun  sticky: a byte was dropped
module rx_byte_buffer (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic [7:0] data,
  output logic       overrun
);

  // A pop frees the slot in the same cycle, so a simultaneous push is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      full    <= 1'b0;
      data    <= 8'h00;
      overrun <= 1'b0;
    end else begin
      if (wr && (!full || rd)) begin
        data <= wr_data;
        full <= 1'b1;
      end else if (rd) begin
        full <= 1'b0;
      end
      if (wr && full && !rd) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_sequencer.sv
// io_sequencer
// Sequences the core's `in` and `out` instructions against the UART byte
// interfaces and stalls the PC while one is in progress. `in` assembles
// NBYTES received bytes (first byte in bits [7:0]) and issues one register
// write pulse; `out` sends NBYTES bytes of a latched register value, lowest
// byte first.
//
// Ports:
//   CLK               clock
//   reset             synchronous active-high reset
//   in_req            decoded `in` instruction present (held while stalled)
//   out_req           decoded `out` instruction present (held while stalled)
//   out_data          value to transmit, sampled when an out begins
//   rx_data/rx_valid  received byte and its one-cycle strobe
//   tx_busy           transmitter busy
//   tx_data/tx_start  byte to transmit and its one-cycle start pulse
//   pc_enable         combinational; 0 stalls PC/fetch
//   reg_write_enable  one-cycle pulse writing reg_write_data
//   reg_write_data    assembled input word
//   overrun           sticky: a received byte was dropped
module io_sequencer
  import io_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        in_req,
  input  logic        out_req,
  input  logic [31:0] out_data,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        pc_enable,
  output logic        reg_write_enable,
  output logic [31:0] reg_write_data,
  output logic        overrun
);

  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(NBYTES - 1);

  state_t             state, state_next;
  logic [COUNT_W-1:0] count, count_next;
  logic [31:0]        word, word_next;
  logic [31:0]        latched, latched_next;
  logic [7:0]         tx_data_next;
  logic               tx_start_next;
  logic               reg_write_enable_next;
  logic [31:0]        reg_write_data_next;

  logic               pend_full;
  logic [7:0]         pend_data;
  logic               take_pend;
  logic               take_direct;
  logic [7:0]         rx_byte;

  // In RX a held byte always goes first; a fresh byte is used directly only
  // when nothing is held, otherwise it is parked in the buffer.
  always_comb begin
    take_pend   = (state == RX) && pend_full;
    take_direct = (state == RX) && !pend_full && rx_valid;
    rx_byte     = take_pend ? pend_data : rx_data;
  end

  rx_byte_buffer u_rx_buffer (
    .clk     (CLK),
    .reset   (reset),
    .wr      (rx_valid && !take_direct),
    .rd      (take_pend),
    .wr_data (rx_data),
    .full    (pend_full),
    .data    (pend_data),
    .overrun (overrun)
  );

  // The stall must apply in the very cycle a request shows up, so this
  // looks at the raw requests rather than waiting for the state change.
  assign pc_enable = ((state == IDLE) && !in_req && !out_req) || (state == DONE);

  always_comb begin
    state_next            = state;
    count_next            = count;
    word_next             = word;
    latched_next          = latched;
    tx_data_next          = tx_data;
    tx_start_next         = 1'b0;
    reg_write_enable_next = 1'b0;
    reg_write_data_next   = reg_write_data;

    case (state)
      IDLE: begin
        if (in_req) begin
          state_next = RX;
          count_next = '0;
          word_next  = '0;
        end else if (out_req) begin
          state_next   = TX_SEND;
          latched_next = out_data;
          count_next   = '0;
        end
      end

      RX: begin
        if (take_pend || take_direct) begin
          word_next[8*count +: 8] = rx_byte;
          if (count == LAST) begin
            state_next            = DONE;
            reg_write_enable_next = 1'b1;
            reg_write_data_next   = word_next;
          end else begin
            count_next = count + 1'b1;
          end
        end
      end

      TX_SEND: begin
        if (!tx_busy) begin
          tx_data_next  = latched[8*count +: 8];
          tx_start_next = 1'b1;
          state_next    = TX_GUARD;
        end
      end

      // tx_busy only rises the cycle after tx_start, so give it one cycle
      // before sampling it again.
      TX_GUARD: begin
        if (count == LAST) begin
          state_next = DONE;
        end else begin
          count_next = count + 1'b1;
          state_next = TX_SEND;
        end
      end

      // Requests are ignored here so a still-held request cannot retrigger.
      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state            <= IDLE;
      count            <= '0;
      word             <= '0;
      latched          <= '0;
      tx_data          <= 8'h00;
      tx_start         <= 1'b0;
      reg_write_enable <= 1'b0;
      reg_write_data   <= '0;
    end else begin
      state            <= state_next;
      count            <= count_next;
      word             <= word_next;
      latched          <= latched_next;
      tx_data          <= tx_data_next;
      tx_start         <= tx_start_next;
      reg_write_enable <= reg_write_enable_next;
      reg_write_data   <= reg_write_data_next;
    end
  end

endmodule

// File: tb/tb_io_sequencer.sv
// tb_io_sequencer
// Directed transaction sequence with randomized data and byte spacing for
// io_sequencer. A transaction-level model tracks the received byte stream
// (with a one-byte holding limit outside a receive) and the expected words
// and transmit bytes.
module tb_io_sequencer;

  localparam int NB = 4;

  logic        clk;
  logic        reset;
  logic        in_req;
  logic        out_req;
  logic [31:0] out_data;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        pc_enable;
  logic        reg_write_enable;
  logic [31:0] reg_write_data;
  logic        overrun;

  int          passed = 0;
  int          total  = 0;

  logic [7:0]  expq[$];
  logic        overrunExp = 1'b0;
  logic [7:0]  txq[$];
  int          txBusyViol = 0;
  int          busyCnt = 0;

  io_sequencer #(.NBYTES(NB)) dut (
    .CLK              (clk),
    .reset            (reset),
    .in_req           (in_req),
    .out_req          (out_req),
    .out_data         (out_data),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .tx_busy          (tx_busy),
    .tx_data          (tx_data),
    .tx_start         (tx_start),
    .pc_enable        (pc_enable),
    .reg_write_enable (reg_write_enable),
    .reg_write_data   (reg_write_data),
    .overrun          (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART transmitter stand-in: busy for 20 cycles starting the cycle after
  // each start pulse.
  always @(posedge clk) begin
    if (reset) busyCnt <= 0;
    else if (tx_start) busyCnt <= 20;
    else if (busyCnt != 0) busyCnt <= busyCnt - 1;
  end
  assign tx_busy = (busyCnt != 0);

  // Collects every transmitted byte and notes starts issued while busy.
  always @(negedge clk) begin
    if (tx_start) begin
      txq.push_back(tx_data);
      if (tx_busy) txBusyViol <= txBusyViol + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Drives one cycle worth of inputs, then moves to the next falling edge.
  task automatic applyStimulus(input logic i, input logic o, input logic v,
                               input logic [7:0] d);
    in_req   = i;
    out_req  = o;
    rx_valid = v;
    rx_data  = d;
    @(negedge clk);
  endtask

  // A byte arriving outside a receive: kept if the holding slot is free.
  task automatic sendIdleByte(input logic [7:0] b);
    if (expq.size() >= 1) overrunExp = 1'b1;
    else expq.push_back(b);
    applyStimulus(1'b0, 1'b0, 1'b1, b);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic doIn(input int nfresh, input int gap, input bit useDir,
                      input logic [31:0] dirWord, input bit withOut, input string tag);
    logic [31:0] expWord;
    logic [7:0]  b;
    int sent, earlyWr, txBase, cyc;
    bit done;
    sent = 0; earlyWr = 0; done = 0; cyc = 0;
    txBase   = txq.size();
    in_req   = 1'b1;
    out_req  = withOut;
    out_data = $urandom;
    while (!done && cyc < 600) begin
      if (sent < nfresh && cyc == (sent + 1) * gap) begin
        b = useDir ? dirWord[8*sent +: 8] : 8'($urandom);
        rx_valid = 1'b1;
        rx_data  = b;
        expq.push_back(b);
        sent++;
      end else begin
        rx_valid = 1'b0;
      end
      #1;
      if (pc_enable) done = 1;
      else begin
        if (reg_write_enable) earlyWr++;
        @(negedge clk);
        cyc++;
      end
    end
    expWord = 32'h0;
    for (int i = 0; i < NB; i++)
      if (expq.size() > 0) expWord[8*i +: 8] = expq.pop_front();
    checkOutput({tag, " done_reached"}, 32'(done), 32'd1);
    checkOutput({tag, " bytes_before_done"}, sent, nfresh);
    checkOutput({tag, " early_write"}, earlyWr, 0);
    checkOutput({tag, " write_pulse"}, 32'(reg_write_enable), 32'd1);
    checkOutput({tag, " write_data"}, reg_write_data, expWord);
    checkOutput({tag, " tx_starts"}, txq.size() - txBase, 0);
    @(negedge clk);
    in_req   = 1'b0;
    out_req  = 1'b0;
    rx_valid = 1'b0;
    #1;
    checkOutput({tag, " pc_after_done"}, 32'(pc_enable), 32'd1);
    checkOutput({tag, " no_second_write"}, 32'(reg_write_enable), 32'd0);
    checkOutput({tag, " overrun"}, 32'(overrun), 32'(overrunExp));
  endtask

  task automatic doOut(input logic [31:0] data, input string tag);
    int txBase, violBase, earlyWr, cyc;
    bit done;
    earlyWr = 0; done = 0; cyc = 0;
    txBase   = txq.size();
    violBase = txBusyViol;
    in_req   = 1'b0;
    out_req  = 1'b1;
    out_data = data;
    rx_valid = 1'b0;
    while (!done && cyc < 600) begin
      #1;
      if (pc_enable) done = 1;
      else begin
        if (reg_write_enable) earlyWr++;
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput({tag, " done_reached"}, 32'(done), 32'd1);
    checkOutput({tag, " tx_count"}, txq.size() - txBase, NB);
    for (int i = 0; i < NB; i++)
      if (txq.size() > txBase + i)
        checkOutput({tag, " tx_byte"}, 32'(txq[txBase + i]), (data >> (8 * i)) & 32'hFF);
    checkOutput({tag, " start_while_busy"}, txBusyViol - violBase, 0);
    checkOutput({tag, " no_write"}, earlyWr, 0);
    @(negedge clk);
    out_req = 1'b0;
    #1;
    checkOutput({tag, " pc_after_done"}, 32'(pc_enable), 32'd1);
  endtask

  initial begin
    reset    = 1'b1;
    in_req   = 1'b0;
    out_req  = 1'b0;
    out_data = 32'h0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset pc_enable", 32'(pc_enable), 32'd1);
    checkOutput("reset reg_write_enable", 32'(reg_write_enable), 32'd0);
    checkOutput("reset reg_write_data", reg_write_data, 32'h0);
    checkOutput("reset tx_start", 32'(tx_start), 32'd0);
    checkOutput("reset tx_data", 32'(tx_data), 32'h0);
    checkOutput("reset overrun", 32'(overrun), 32'd0);
    @(negedge clk);

    doIn(4, 10, 1'b1, 32'h12345678, 1'b0, "in4");
    doOut(32'hDEADBEEF, "out4");

    sendIdleByte(8'hAA);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    doIn(3, 4, 1'b1, 32'h00DDCCBB, 1'b0, "early");

    sendIdleByte(8'h01);
    sendIdleByte(8'h02);
    checkOutput("overrun set", 32'(overrun), 32'd1);
    doIn(3, $urandom_range(1, 8), 1'b0, 32'h0, 1'b0, "after_overrun");

    doIn(4, $urandom_range(1, 8), 1'b0, 32'h0, 1'b1, "simultaneous");

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h11);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h22);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    expq.delete();
    overrunExp = 1'b0;
    #1;
    checkOutput("midreset pc_enable", 32'(pc_enable), 32'd1);
    checkOutput("midreset overrun", 32'(overrun), 32'd0);
    checkOutput("midreset reg_write_data", reg_write_data, 32'h0);
    @(negedge clk);
    doIn(4, 3, 1'b1, 32'h04030201, 1'b0, "post_reset");

    for (int t = 0; t < 6; t++) begin
      if ($urandom_range(0, 1) == 1) doIn(4, $urandom_range(1, 12), 1'b0, 32'h0, 1'b0, "rand_in");
      else doOut($urandom, "rand_out");
      @(negedge clk);
    end

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/io_sequencer.md
Name: io_sequencer

Overview:
- Sequences the core's `in` and `out` I/O instructions against the UART byte interfaces.
- Stalls the PC while an I/O instruction is in progress.
- For `in`: assembles NBYTES received bytes into one word, then issues a single register-write pulse toward write-back.
- For `out`: serialises a 32-bit register value into NBYTES transmit bytes.
- Sits between decode/write-back and the UART rx/tx modules. It replaces ad-hoc stall logic inside the write-back stage.

Parameters:
- NBYTES, 4, number of bytes per `in`/`out` transfer (legal range 1..4).

Ports:
- CLK  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_req  input  1  decoded `in` instruction present; held by the core while stalled.
- out_req  input  1  decoded `out` instruction present; held while stalled.
- out_data  input  32  register value to transmit; sampled when an out begins.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle pulse: rx_data is valid.
- tx_busy  input  1  transmitter busy; high from the cycle after tx_start until the byte is sent.
- tx_data  output  8  byte to transmit.
- tx_start  output  1  one-cycle pulse: transmit tx_data.
- pc_enable  output  1  combinational; 0 stalls PC/fetch.
- reg_write_enable  output  1  one-cycle pulse: write reg_write_data.
- reg_write_data  output  32  assembled input word.
- overrun  output  1  sticky: a received byte was dropped.

Behaviour:
- Reset: state=IDLE, count=0, word=0, pending buffer empty, overrun=0, tx_start=0, tx_data=0, reg_write_enable=0, reg_write_data=0. Reset mid-transfer discards the partial word/bytes; pc_enable=1 on the next cycle.
- pc_enable: 1 when (state==IDLE && !in_req && !out_req) or when state==DONE; otherwise 0. The stall therefore takes effect in the same cycle the request appears.
- States: IDLE, RX, TX_SEND, TX_GUARD, DONE.
- IDLE:
  - in_req → RX, count=0, word=0.
  - else out_req → TX_SEND, latch out_data, count=0.
  - in_req has priority if both requests are high.
- RX, byte source:
  - If the pending buffer is full, consume it.
  - Else, if rx_valid, consume rx_data.
  - Consumed byte goes to word[8*count +: 8]; the first byte received lands in bits [7:0].
  - Unused upper bytes are 0 when NBYTES<4.
- RX, completion: when count==NBYTES-1 and a byte is consumed:
  - go to DONE;
  - reg_write_enable=1 for exactly one cycle (registered, coincident with DONE);
  - reg_write_data = final word, held until the next completion.
  - Otherwise count++.
- Pending buffer (1 byte):
  - rx_valid while not consuming it (any state), or while the pending byte is consumed the same cycle, writes it into pending.
  - rx_valid with pending full and pending not consumed: byte dropped, overrun=1 (sticky until reset).
- TX_SEND: when !tx_busy, tx_data = latched[8*count +: 8] (first byte is bits [7:0]), tx_start=1 for one cycle, then go to TX_GUARD.
- TX_GUARD: one cycle so tx_busy can rise. Then:
  - if count==NBYTES-1 → DONE;
  - else count++ → TX_SEND.
- The sequencer does not wait for the final byte to finish transmitting.
- DONE: lasts one cycle with pc_enable=1, so the PC advances. Next state is IDLE. in_req/out_req are ignored in DONE, so a held request cannot retrigger.
- Simultaneous events: rx_valid during TX or IDLE is buffered, never lost unless pending is already full.

Decomposition:
- Package io_seq_pkg: state enum (IDLE, RX, TX_SEND, TX_GUARD, DONE), and count width localparam (2 bits).
- Sub-module rx_byte_buffer: 1-byte pending register with push/pop/full and overrun flag. The FSM, assembly and tx logic stay in io_sequencer.

Test Plan:
- in, 4-byte receive:
  - Stimulus: in_req held; rx_valid pulses with bytes 78,56,34,12 spaced 10 cycles.
  - Required: pc_enable=0 until DONE; one reg_write_enable pulse with reg_write_data=0x12345678; pc_enable=1 exactly one cycle; no second write while in_req is still high in DONE.
- out, 4-byte transmit:
  - Stimulus: out_req with out_data=0xDEADBEEF; tx_busy modelled high for 20 cycles after each start.
  - Required: tx_data sequence EF,BE,AD,DE; each tx_start only when tx_busy=0; pc_enable=0 until DONE.
- Early byte:
  - Stimulus: byte 0xAA arrives in IDLE; in_req arrives 5 cycles later with bytes BB,CC,DD.
  - Required: reg_write_data=0xDDCCBBAA; overrun=0.
- Overrun:
  - Stimulus: in IDLE, rx_valid twice (0x01 then 0x02).
  - Required: overrun=1; a subsequent in consumes 0x01 first.
- Simultaneous requests:
  - Stimulus: in_req=out_req=1.
  - Required: RX entered; no tx_start pulses.
- Reset mid-transfer:
  - Stimulus: reset after 2 of 4 RX bytes.
  - Required: next cycle pc_enable=1, overrun=0; a fresh in with 4 bytes 01,02,03,04 yields 0x04030201.
